cpu_run_monitor: RTL and testbench

//  Parametrised run-control/monitor for the 5-stage pipeline CPU; generalises the fixed-delay sim harness.

---
 rtl/cpu_run_monitor_pkg.sv | 28 ++
 rtl/cpu_run_monitor_sat_counter.sv | 44 ++++
 rtl/cpu_run_monitor.sv | 152 +++++++++++++++
 tb/tb_cpu_run_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_monitor_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor_pkg
//   Shared definitions for the CPU run monitor: FSM state encodings, run
//   status codes and a width helper. Benches and the CPU top import this
//   package so they use the same codes as the monitor.
// ---------------------------------------------------------------------------
package cpu_run_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_HALTED  = 2'd1,
        ST_STALLED = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cpu_run_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter: sticks at all-ones instead of wrapping.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high reset (q -> 0)
//     clr   - synchronous clear, wins over inc
//     inc   - increment by one when not saturated
//     q     - current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
//   Run-control monitor for the pipelined CPU. After a start pulse it waits
//   out a warm-up window, then watches the fetch PC every cycle and ends the
//   run on halt PC, stuck PC or timeout, latching status and counters.
//   Ports:
//     clk, reset      - clock; asynchronous active-high reset
//     pc              - current fetch PC
//     start           - one-cycle pulse, accepted only in IDLE or DONE
//     busy            - high in WARMUP and RUN
//     done            - high in DONE until the next start or reset
//     status          - 0 none, 1 halted, 2 stalled, 3 timeout
//     cycle_count     - WARMUP+RUN cycles of the current/last run (saturating)
//     pc_change_count - RUN cycles whose pc differed from the previous pc
//     last_pc         - pc presented on the final RUN cycle
// ---------------------------------------------------------------------------
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     CNT_W          = 32,
    parameter int unsigned     WARMUP         = 5,
    parameter int unsigned     STALL_LIMIT    = 8,
    parameter int unsigned     TIMEOUT_CYCLES = 60,
    parameter logic [XLEN-1:0] HALT_PC        = 32'hFFFF_FFFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] pc_change_count,
    output logic [XLEN-1:0]  last_pc
);

    // Phase counter counts warm-up cycles, then is cleared and counts RUN cycles.
    localparam int PH_MAX = (WARMUP > TIMEOUT_CYCLES) ? WARMUP : TIMEOUT_CYCLES;
    localparam int PW     = cnt_width(PH_MAX);
    localparam int SW     = cnt_width(STALL_LIMIT);

    // "count + 1 == limit" is evaluated as "count == limit - 1".
    localparam logic [PW-1:0] WARM_LAST  = PW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PW-1:0] TO_LAST    = PW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    state_e          state_q, state_d;
    status_e         status_q, status_d;
    status_e         end_code;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [PW-1:0]   phase_cnt;
    logic [SW-1:0]   stall_cnt;

    logic in_warm, in_run, start_acc, pc_changed, warm_last;
    logic halt_hit, stall_hit, timeout_hit;

    assign in_warm    = (state_q == S_WARMUP);
    assign in_run     = (state_q == S_RUN);
    assign start_acc  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign pc_changed = (pc != pc_q);
    assign warm_last  = in_warm && (phase_cnt == WARM_LAST);

    assign halt_hit    = (pc == HALT_PC);
    assign stall_hit   = (stall_cnt == STALL_LAST) && !pc_changed;
    assign timeout_hit = (phase_cnt == TO_LAST);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .inc(in_warm || in_run), .q(cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_change_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .inc(in_run && pc_changed), .q(pc_change_count)
    );

    sat_counter #(.W(SW)) u_stall_cnt (
        .clk(clk), .reset(reset), .clr(start_acc || (in_run && pc_changed)),
        .inc(in_run && !pc_changed), .q(stall_cnt)
    );

    sat_counter #(.W(PW)) u_phase_cnt (
        .clk(clk), .reset(reset), .clr(start_acc || warm_last),
        .inc(in_warm || in_run), .q(phase_cnt)
    );

    // End condition priority: halted, then stalled, then timeout.
    always_comb begin
        end_code = ST_NONE;
        if (halt_hit) begin
            end_code = ST_HALTED;
        end else if (stall_hit) begin
            end_code = ST_STALLED;
        end else if (timeout_hit) begin
            end_code = ST_TIMEOUT;
        end
    end

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        pc_d      = pc_q;
        last_pc_d = last_pc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = (WARMUP == 0) ? S_RUN : S_WARMUP;
                    status_d  = ST_NONE;
                    last_pc_d = '0;
                    // Captured so a zero-length warm-up still gives RUN a reference pc.
                    pc_d      = pc;
                end
            end
            S_WARMUP: begin
                pc_d = pc;
                if (warm_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                pc_d = pc;
                if (end_code != ST_NONE) begin
                    state_d   = S_DONE;
                    status_d  = end_code;
                    last_pc_d = pc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            status_q  <= ST_NONE;
            pc_q      <= '0;
            last_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            pc_q      <= pc_d;
            last_pc_q <= last_pc_d;
        end
    end

    assign busy    = in_warm || in_run;
    assign done    = (state_q == S_DONE);
    assign status  = status_q;
    assign last_pc = last_pc_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_monitor
//   Instance A uses default parameters; instance B uses CNT_W=4, WARMUP=20,
//   STALL_LIMIT=1, TIMEOUT_CYCLES=1 so all end conditions can coincide and
//   the cycle counter saturates. Expected run results are queued before each
//   start; a monitor pops and compares them when done rises.
// ---------------------------------------------------------------------------
module tb_cpu_run_monitor;
    import cpu_run_monitor_pkg::*;

    localparam logic [31:0] HALT = 32'hFFFF_FFFC;

    typedef struct {
        int          dut;
        logic [1:0]  status;
        logic [31:0] cc;
        logic [31:0] pcc;
        logic [31:0] last_pc;
        int          busy_cycles;
    } exp_t;

    logic        clk, reset;
    logic [31:0] pc_a, pc_b;
    logic        start_a, start_b;

    logic        busy_a, done_a, busy_b, done_b;
    logic [1:0]  status_a, status_b;
    logic [31:0] cc_a, pcc_a, last_a, last_b;
    logic [3:0]  cc_b, pcc_b;

    logic        busy_w   [2];
    logic        done_w   [2];
    logic [1:0]  status_w [2];
    logic [31:0] cc_w     [2];
    logic [31:0] pcc_w    [2];
    logic [31:0] last_w   [2];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    cpu_run_monitor u_dut_a (
        .clk(clk), .reset(reset), .pc(pc_a), .start(start_a),
        .busy(busy_a), .done(done_a), .status(status_a),
        .cycle_count(cc_a), .pc_change_count(pcc_a), .last_pc(last_a)
    );

    cpu_run_monitor #(.CNT_W(4), .WARMUP(20), .STALL_LIMIT(1), .TIMEOUT_CYCLES(1)) u_dut_b (
        .clk(clk), .reset(reset), .pc(pc_b), .start(start_b),
        .busy(busy_b), .done(done_b), .status(status_b),
        .cycle_count(cc_b), .pc_change_count(pcc_b), .last_pc(last_b)
    );

    assign busy_w[0] = busy_a;   assign busy_w[1] = busy_b;
    assign done_w[0] = done_a;   assign done_w[1] = done_b;
    assign status_w[0] = status_a; assign status_w[1] = status_b;
    assign cc_w[0] = cc_a;       assign cc_w[1] = {28'd0, cc_b};
    assign pcc_w[0] = pcc_a;     assign pcc_w[1] = {28'd0, pcc_b};
    assign last_w[0] = last_a;   assign last_w[1] = last_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic step(input int d, input logic [31:0] p, input logic s);
        @(negedge clk);
        if (d == 0) begin
            pc_a = p; start_a = s;
        end else begin
            pc_b = p; start_b = s;
        end
    endtask

    task automatic expect_run(input int d, input logic [1:0] st, input logic [31:0] cc,
                              input logic [31:0] pcc, input logic [31:0] lp, input int bc);
        exp_t e;
        e.dut = d; e.status = st; e.cc = cc; e.pcc = pcc; e.last_pc = lp; e.busy_cycles = bc;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int d);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            seen = done_w[d];
        end
        check("done_within_bound", {31'd0, seen}, 32'd1);
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_busy"},   {31'd0, busy_w[d]}, 32'd0);
        check({tag, "_done"},   {31'd0, done_w[d]}, 32'd0);
        check({tag, "_status"}, {30'd0, status_w[d]}, 32'd0);
        check({tag, "_cc"},     cc_w[d], 32'd0);
        check({tag, "_pcc"},    pcc_w[d], 32'd0);
        check({tag, "_last"},   last_w[d], 32'd0);
    endtask

    // Monitor: invariants every cycle, result comparison on done rising, hold while done.
    int   busy_cnt [2];
    logic done_prev [2];
    logic have_exp [2];
    exp_t cur_exp [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                busy_cnt[i]  = 0;
                done_prev[i] = 1'b0;
                have_exp[i]  = 1'b0;
            end else begin
                check("busy_done_exclusive", {31'd0, busy_w[i] && done_w[i]}, 32'd0);
                check("status_iff_done", {31'd0, status_w[i] != 2'd0}, {31'd0, done_w[i]});
                if (busy_w[i]) busy_cnt[i]++;
                if (done_w[i] && !done_prev[i]) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: dut %0d finished with no queued run", i);
                        have_exp[i] = 1'b0;
                    end else begin
                        cur_exp[i]  = exp_q.pop_front();
                        have_exp[i] = 1'b1;
                        check("run_dut",     i, cur_exp[i].dut);
                        check("run_status",  {30'd0, status_w[i]}, {30'd0, cur_exp[i].status});
                        check("run_cycles",  cc_w[i], cur_exp[i].cc);
                        check("run_changes", pcc_w[i], cur_exp[i].pcc);
                        check("run_last_pc", last_w[i], cur_exp[i].last_pc);
                        check("run_busy_len", busy_cnt[i], cur_exp[i].busy_cycles);
                    end
                    busy_cnt[i] = 0;
                end else if (done_w[i] && have_exp[i]) begin
                    check("hold_status", {30'd0, status_w[i]}, {30'd0, cur_exp[i].status});
                    check("hold_cycles", cc_w[i], cur_exp[i].cc);
                    check("hold_last_pc", last_w[i], cur_exp[i].last_pc);
                end
                done_prev[i] = done_w[i];
            end
        end
    end

    initial begin
        reset = 1'b1; pc_a = '0; pc_b = '0; start_a = 1'b0; start_b = 1'b0;
        #12;
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        @(negedge clk) reset = 1'b0;

        // Halt on RUN cycle 10 after nine +4 steps from pc 0.
        expect_run(0, ST_HALTED, 32'd15, 32'd10, HALT, 15);
        step(0, 32'h0, 1'b1);
        repeat (5) step(0, 32'h0, 1'b0);
        for (int k = 1; k <= 9; k++) step(0, 32'(4 * k), 1'b0);
        step(0, HALT, 1'b0);
        wait_done(0);
        repeat (3) step(0, 32'h1234, 1'b1 ^ 1'b1);

        // Restart from DONE, stuck pc 0x40, with start pulses while busy.
        expect_run(0, ST_STALLED, 32'd13, 32'd0, 32'h40, 13);
        step(0, 32'h40, 1'b1);
        step(0, 32'h40, 1'b0);
        check("restart_busy", {31'd0, busy_a}, 32'd1);
        check("restart_done", {31'd0, done_a}, 32'd0);
        check("restart_status", {30'd0, status_a}, 32'd0);
        check("restart_cc", cc_a, 32'd0);
        check("restart_pcc", pcc_a, 32'd0);
        check("restart_last", last_a, 32'd0);
        step(0, 32'h40, 1'b1);
        repeat (3) step(0, 32'h40, 1'b0);
        repeat (3) step(0, 32'h40, 1'b0);
        step(0, 32'h40, 1'b1);
        repeat (4) step(0, 32'h40, 1'b0);
        wait_done(0);

        // Timeout: pc moves every cycle for 60 RUN cycles.
        expect_run(0, ST_TIMEOUT, 32'd65, 32'd60, 32'h10F0, 65);
        step(0, 32'h1000, 1'b1);
        repeat (5) step(0, 32'h1000, 1'b0);
        for (int k = 1; k <= 60; k++) step(0, 32'h1000 + 32'(4 * k), 1'b0);
        wait_done(0);

        // Instance B: halt, stall and timeout all on RUN cycle 1 -> halted.
        expect_run(1, ST_HALTED, 32'd15, 32'd0, HALT, 21);
        step(1, HALT, 1'b1);
        repeat (21) step(1, HALT, 1'b0);
        wait_done(1);

        // Stall and timeout together -> stalled.
        expect_run(1, ST_STALLED, 32'd15, 32'd0, 32'h80, 21);
        step(1, 32'h80, 1'b1);
        repeat (21) step(1, 32'h80, 1'b0);
        wait_done(1);

        // Timeout alone.
        expect_run(1, ST_TIMEOUT, 32'd15, 32'd1, 32'h14, 21);
        step(1, 32'h10, 1'b1);
        repeat (20) step(1, 32'h10, 1'b0);
        step(1, 32'h14, 1'b0);
        wait_done(1);

        // Asynchronous reset in the middle of a RUN, away from the clock edge.
        step(0, 32'h200, 1'b1);
        repeat (5) step(0, 32'h200, 1'b0);
        step(0, 32'h204, 1'b0);
        step(0, 32'h208, 1'b0);
        step(0, 32'h20C, 1'b0);
        check("pre_reset_busy", {31'd0, busy_a}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_zero(0, "midrun_reset_a");
        check_zero(1, "midrun_reset_b");
        @(negedge clk);
        #2 reset = 1'b0;

        // Clean run after reset release.
        expect_run(0, ST_HALTED, 32'd9, 32'd4, HALT, 9);
        step(0, 32'h300, 1'b1);
        repeat (5) step(0, 32'h300, 1'b0);
        for (int k = 1; k <= 3; k++) step(0, 32'h300 + 32'(4 * k), 1'b0);
        step(0, HALT, 1'b0);
        wait_done(0);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
